riscv_mc_controller: RTL and testbench
======================================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, width of the ALUControl code.
REQ-002 SHALL have port clk  in  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port op  in  7  opcode from the instruction register (Inst[6:0]).
REQ-005 SHALL have port funct3  in  3  Inst[14:12].
REQ-006 SHALL have port funct7b5  in  1  Inst[30].
REQ-007 SHALL have port zero  in  1  ALU zero flag.
REQ-008 SHALL have these outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite (1 each); ResultSrc, ALUSrcA, ALUSrcB, ImmSrc (2 each); ALUControl (ALUCTRL_W); instr_done (1); illegal (1); state (4, debug).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and ILLEGAL.
REQ-010 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> ILLEGAL.
- MEMADR: op 0000011 -> MEMREAD, otherwise -> MEMWRITE.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECR, EXECI, JAL -> ALUWB->FETCH.
- BEQ->FETCH.
- ILLEGAL->ILLEGAL.
REQ-011 Mux encodings SHALL be:
- AdrSrc: 0=PC, 1=Result.
- ALUSrcA: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB: 00=RD2, 01=ImmExt, 10=constant 4.
- ResultSrc: 00=ALUOut, 01=ReadData, 10=ALUResult.
REQ-012 Per-state outputs SHALL be as below; any output not listed for a state SHALL be 0.
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-013 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinationally within the same cycle.
REQ-014 ImmSrc SHALL be a combinational decode of op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all others -> 00.
REQ-015 ALUControl SHALL be derived from ALUOp as follows:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
- ALUOp 10 with funct3 000 -> 001 if {op[5],funct7b5}=11, else 000.
- ALUOp 10 with funct3 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); any other funct3 -> 000.
REQ-016 instr_done SHALL pulse for one cycle in MEMWB, MEMWRITE, ALUWB and BEQ only.
REQ-017 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type ALU and jal 4; beq 3.
REQ-018 In ILLEGAL, illegal SHALL be 1 and PCWrite, MemWrite, RegWrite and IRWrite SHALL all be 0, until reset.
REQ-019 op, funct3 and funct7b5 SHALL be sampled only in DECODE and MEMADR (and ALU states for decode); they are held stable by the instruction register.

Reset
REQ-020 rst=1 at a rising edge SHALL force state=FETCH on that edge, regardless of the current state, including mid-instruction and ILLEGAL.
REQ-021 While rst=1, all write enables SHALL be 0 and instr_done=0 and illegal=0; after release, the first cycle SHALL be FETCH with IRWrite=1 and PCWrite=1.

Structure
REQ-022 A shared package riscv_ctrl_pkg SHALL hold the state encoding, the opcode constants, the ALUOp/ALUControl codes and the mux-select encodings.
REQ-023 ALU decoding (REQ-015) SHALL be a sub-module alu_decoder; the FSM and ImmSrc decode SHALL stay in riscv_mc_controller.

Verification
REQ-024 lw (op=0000011): the bench SHALL check the state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB, with RegWrite=1 and instr_done=1 only in cycle 5 and AdrSrc=1 in cycle 4.
REQ-025 beq (op=1100011): with zero=1, PCWrite=1 in the BEQ cycle; with zero=0, PCWrite=0; both cases return to FETCH on the next edge.
REQ-026 R-type (op=0110011, funct3=000): funct7b5=1 -> ALUControl=001 in EXECR; funct7b5=0 -> 000. funct3=111 -> 010.
REQ-027 op=0000000: FSM enters ILLEGAL and holds illegal=1 with all write enables 0 for 10 cycles; rst=1 then returns the FSM to FETCH.
REQ-028 sw (op=0100011): assert rst during MEMWRITE; the next cycle SHALL be FETCH with MemWrite=0, and ImmSrc=01 while op is held.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller:
// states, opcodes, ALU codes, mux selects and per-state controls.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    c.adr_src    = ADR_PC;
    c.result_src = RES_ALUOUT;
    c.alu_src_a  = SRCA_PC;
    c.alu_src_b  = SRCB_RD2;
    c.alu_op     = ALUOP_ADD;
    unique case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = ADR_RESULT;
      S_MEMWB: begin
        c.result_src = RES_READDATA;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = ADR_RESULT;
        c.mem_write = 1'b1;
        c.done      = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALUControl decode from ALUOp, funct3 and the sub/add
// distinguishing bits of the instruction.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 op5,
  input  logic                 funct7b5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNC: begin
        unique case (funct3)
          3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM with registered
// per-state controls, ImmSrc decode and the ALU decoder.
module riscv_mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [3:0]           state
);

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl;
  logic   live;

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_JAL:      nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_ILLEGAL:  nxt = S_ILLEGAL;
      default:    nxt = S_ILLEGAL;
    endcase
  end

  // Controls are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= S_FETCH;
      ctrl <= state_ctrl(S_FETCH);
    end else begin
      cur  <= nxt;
      ctrl <= state_ctrl(nxt);
    end
  end

  // Enables stay quiet while reset is held.
  assign live       = ~rst;
  assign PCWrite    = live & (ctrl.pc_update | (ctrl.branch & zero));
  assign MemWrite   = live & ctrl.mem_write;
  assign IRWrite    = live & ctrl.ir_write;
  assign RegWrite   = live & ctrl.reg_write;
  assign instr_done = live & ctrl.done;
  assign illegal    = live & ctrl.illegal;
  assign AdrSrc     = ctrl.adr_src;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign state      = cur;

  always_comb begin
    ImmSrc = IMM_I;
    unique case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .alu_op     (ctrl.alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(ALUControl)
  );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed and randomized checks of the multicycle controller
// against an instruction-level model of its control outputs.
module tb_riscv_mc_controller;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alc;
    logic       done, ill;
  } obs_t;

  state_t exp_q[$];
  obs_t   obs_log[$];

  riscv_mc_controller #(.ALUCTRL_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.adr = AdrSrc;
    o.mw = MemWrite; o.irw = IRWrite; o.rw = RegWrite;
    o.rs = ResultSrc; o.sa = ALUSrcA; o.sb = ALUSrcB;
    o.imm = ImmSrc; o.alc = ALUControl;
    o.done = instr_done; o.ill = illegal;
    return o;
  endfunction

  function automatic logic [2:0] fdec(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    case (o)
      7'b0100011: return 2'd1;
      7'b1100011: return 2'd2;
      7'b1101111: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  // Expected outputs of a cycle spent in state s.
  function automatic obs_t exp_of(state_t s, logic [6:0] o,
      logic [2:0] f3, logic f7, logic z, logic r);
    obs_t e;
    e = '0;
    e.st = s;
    e.imm = imm_of(o);
    case (s)
      S_FETCH:    begin e.irw = 1; e.sb = 2; e.rs = 2; e.pcw = 1; end
      S_DECODE:   begin e.sa = 1; e.sb = 1; end
      S_MEMADR:   begin e.sa = 2; e.sb = 1; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.rs = 1; e.rw = 1; e.done = 1; end
      S_MEMWRITE: begin e.adr = 1; e.mw = 1; e.done = 1; end
      S_EXECR:    begin e.sa = 2; e.alc = fdec(o, f3, f7); end
      S_EXECI:    begin e.sa = 2; e.sb = 1; e.alc = fdec(o, f3, f7); end
      S_ALUWB:    begin e.rw = 1; e.done = 1; end
      S_BEQ:      begin e.sa = 2; e.alc = 3'b001; e.pcw = z; e.done = 1; end
      S_JAL:      begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      default:    e.ill = 1;
    endcase
    if (r) begin
      e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; e.done = 0; e.ill = 0;
    end
    return e;
  endfunction

  // State walk of one instruction, by class.
  function automatic void load_seq(logic [6:0] o);
    exp_q = {};
    exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    case (o)
      7'b0000011: begin
        exp_q.push_back(S_MEMADR);
        exp_q.push_back(S_MEMREAD);
        exp_q.push_back(S_MEMWB);
      end
      7'b0100011: begin
        exp_q.push_back(S_MEMADR);
        exp_q.push_back(S_MEMWRITE);
      end
      7'b0110011: begin
        exp_q.push_back(S_EXECR);
        exp_q.push_back(S_ALUWB);
      end
      7'b0010011: begin
        exp_q.push_back(S_EXECI);
        exp_q.push_back(S_ALUWB);
      end
      7'b1101111: begin
        exp_q.push_back(S_JAL);
        exp_q.push_back(S_ALUWB);
      end
      7'b1100011: exp_q.push_back(S_BEQ);
      default:    exp_q.push_back(S_ILLEGAL);
    endcase
  endfunction

  task automatic run_instr(string tag, logic [6:0] o, logic [2:0] f3,
      logic f7, int zmode);
    obs_t got;
    op = o; funct3 = f3; funct7b5 = f7;
    load_seq(o);
    obs_log = {};
    for (int k = 0; k < exp_q.size(); k++) begin
      zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      #1;
      got = observe();
      obs_log.push_back(got);
      chk($sformatf("%s_c%0d", tag, k), 32'(got),
          32'(exp_of(exp_q[k], o, f3, f7, zero, 1'b0)));
      tick();
    end
  endtask

  logic [6:0] ops [6];

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1100011, 7'b1101111};
    rst = 1; op = 0; funct3 = 0; funct7b5 = 0; zero = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 32'(observe()),
        32'(exp_of(S_FETCH, op, funct3, funct7b5, zero, 1'b1)));
    rst = 0;
    #1;
    chk("reset_rel_irw", 32'(IRWrite), 32'd1);
    chk("reset_rel_pcw", 32'(PCWrite), 32'd1);
    chk("reset_rel_st", 32'(state), 32'(S_FETCH));

    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lw_rw_c%0d", k), 32'(obs_log[k].rw), 32'(k == 4));
      chk($sformatf("lw_done_c%0d", k), 32'(obs_log[k].done), 32'(k == 4));
      chk($sformatf("lw_adr_c%0d", k), 32'(obs_log[k].adr), 32'(k == 3));
    end

    run_instr("beq1", 7'b1100011, 3'b000, 1'b0, 1);
    chk("beq1_pcw", 32'(obs_log[2].pcw), 32'd1);
    chk("beq1_ret", 32'(state), 32'(S_FETCH));
    run_instr("beq0", 7'b1100011, 3'b000, 1'b0, 0);
    chk("beq0_pcw", 32'(obs_log[2].pcw), 32'd0);
    chk("beq0_ret", 32'(state), 32'(S_FETCH));

    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 0);
    chk("r_sub_alc", 32'(obs_log[2].alc), 32'b001);
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 0);
    chk("r_add_alc", 32'(obs_log[2].alc), 32'b000);
    run_instr("and", 7'b0110011, 3'b111, 1'b0, 0);
    chk("r_and_alc", 32'(obs_log[2].alc), 32'b010);

    // Illegal opcode: locks up until reset.
    op = 7'b0000000; zero = 0;
    #1;
    chk("ill_f", 32'(observe()), 32'(exp_of(S_FETCH, op, 3'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    chk("ill_d", 32'(observe()), 32'(exp_of(S_DECODE, op, 3'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    for (int k = 0; k < 10; k++) begin
      zero = 1'($urandom);
      #1;
      chk($sformatf("ill_hold_c%0d", k), 32'(observe()),
          32'(exp_of(S_ILLEGAL, op, funct3, funct7b5, zero, 1'b0)));
      tick();
    end
    rst = 1;
    tick();
    chk("ill_rst", 32'(observe()),
        32'(exp_of(S_FETCH, op, funct3, funct7b5, zero, 1'b1)));
    rst = 0;

    // Reset landing in the middle of a store.
    op = 7'b0100011; funct3 = 3'b010; zero = 0;
    tick(); tick(); tick();
    chk("sw_mw_st", 32'(state), 32'(S_MEMWRITE));
    rst = 1;
    tick();
    chk("sw_rst_st", 32'(state), 32'(S_FETCH));
    chk("sw_rst_mw", 32'(MemWrite), 32'd0);
    chk("sw_rst_imm", 32'(ImmSrc), 32'd1);
    rst = 0;
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr($sformatf("rnd%0d", n), ops[$urandom_range(0, 5)],
                3'($urandom), 1'($urandom), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
